// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and types for the address controller.
// Default geometry is 720x480 active inside an 858x525 raster.
package vga_timing_pkg;

  localparam int H_ACT   = 720;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 62;
  localparam int H_BP    = 60;
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;

  localparam int V_ACT   = 480;
  localparam int V_FP    = 9;
  localparam int V_SYNC  = 6;
  localparam int V_BP    = 30;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam int RD_LAT_DEFAULT = 1;
  localparam int ADDR_W  = 19;
  localparam int CNT_W   = 10;
  localparam int COLOR_W = 10;
  localparam int SEL_W   = 3;

  localparam logic [SEL_W-1:0] SEL_RESET = 3'b001;

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
  } vga_ctrl_t;

  localparam vga_ctrl_t CTRL_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a synchronous reset value, used to
// align raster control bits with pixel data returning from the image source.
module vga_delay_line #(
  parameter int                DEPTH   = 1,
  parameter int                WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_addr_ctrl.sv
// Raster timing, linear image addressing and DAC output stage for a VGA
// display fed from an image memory with RD_LAT cycles of read latency.
module vga_addr_ctrl
  import vga_timing_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEFAULT,
  parameter int HACT   = H_ACT,
  parameter int HFP    = H_FP,
  parameter int HSYNC  = H_SYNC,
  parameter int HBP    = H_BP,
  parameter int VACT   = V_ACT,
  parameter int VFP    = V_FP,
  parameter int VSYNC  = V_SYNC,
  parameter int VBP    = V_BP
) (
  input  logic               VGA_CTRL_CLK,
  input  logic               DLY_RST_2,
  input  logic [SEL_W-1:0]   iSEL,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic [ADDR_W-1:0]  oADDR,
  output logic [SEL_W-1:0]   oSEL,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK_N,
  output logic               oVGA_SYNC_N,
  output logic               oFRAME_START
);

  localparam int HTOT = HACT + HFP + HSYNC + HBP;
  localparam int VTOT = VACT + VFP + VSYNC + VBP;

  localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(HTOT - 1);
  localparam logic [CNT_W-1:0]  V_LAST    = CNT_W'(VTOT - 1);
  localparam logic [CNT_W-1:0]  H_ACT_END = CNT_W'(HACT);
  localparam logic [CNT_W-1:0]  V_ACT_END = CNT_W'(VACT);
  localparam logic [CNT_W-1:0]  HS_BEG    = CNT_W'(HACT + HFP);
  localparam logic [CNT_W-1:0]  HS_END    = CNT_W'(HACT + HFP + HSYNC - 1);
  localparam logic [CNT_W-1:0]  VS_BEG    = CNT_W'(VACT + VFP);
  localparam logic [CNT_W-1:0]  VS_END    = CNT_W'(VACT + VFP + VSYNC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(HACT * VACT - 1);

  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               blank_n_q, blank_n_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;

  logic      h_last, v_last, active, frame_start;
  vga_ctrl_t ctrl_raw, ctrl_dly;

  assign h_last      = (h_cnt_q == H_LAST);
  assign v_last      = (v_cnt_q == V_LAST);
  assign active      = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0) && !DLY_RST_2;

  assign ctrl_raw.active = active;
  assign ctrl_raw.hs_n   = !in_window(h_cnt_q, HS_BEG, HS_END);
  assign ctrl_raw.vs_n   = !in_window(v_cnt_q, VS_BEG, VS_END);

  // The address stops at the last pixel so it never leaves the image range.
  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
    end
    addr_d = addr_q;
    if (h_last && v_last) begin
      addr_d = '0;
    end else if (active && (addr_q != ADDR_LAST)) begin
      addr_d = addr_q + ADDR_W'(1);
    end
    sel_d = frame_start ? iSEL : sel_q;
  end

  always_ff @(posedge VGA_CTRL_CLK) begin
    if (DLY_RST_2) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      addr_q  <= '0;
      sel_q   <= SEL_RESET;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
    end
  end

  vga_delay_line #(
    .DEPTH   (RD_LAT),
    .WIDTH   ($bits(vga_ctrl_t)),
    .RST_VAL (CTRL_IDLE)
  ) u_ctrl_dly (
    .clk_i (VGA_CTRL_CLK),
    .rst_i (DLY_RST_2),
    .d_i   (ctrl_raw),
    .q_o   (ctrl_dly)
  );

  // Final stage lines up with the memory data, adding the one register cycle.
  always_comb begin
    blank_n_d = ctrl_dly.active;
    hs_d      = ctrl_dly.hs_n;
    vs_d      = ctrl_dly.vs_n;
    r_d       = ctrl_dly.active ? iRed   : '0;
    g_d       = ctrl_dly.active ? iGreen : '0;
    b_d       = ctrl_dly.active ? iBlue  : '0;
  end

  always_ff @(posedge VGA_CTRL_CLK) begin
    if (DLY_RST_2) begin
      blank_n_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      blank_n_q <= blank_n_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign oADDR        = addr_q;
  assign oSEL         = sel_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_N = blank_n_q;
  assign oVGA_SYNC_N  = 1'b0;
  assign oFRAME_START = frame_start;

endmodule

// File: tb/tb_vga_addr_ctrl.sv
// Bench for vga_addr_ctrl: two full-size instances (read latency 1 and 2)
// plus a small-raster instance so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_addr_ctrl;

  typedef struct packed {
    int hact; int hfp; int hsync; int hbp;
    int vact; int vfp; int vsync; int vbp;
  } geom_t;

  typedef struct packed {
    int   h;
    int   v;
    logic act;
    logic hsN;
    logic vsN;
    int   addr;
  } pos_t;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] isel = 3'b001;

  logic [9:0]  red [NDUT];
  logic [9:0]  green [NDUT];
  logic [9:0]  blue [NDUT];
  logic [18:0] addr [NDUT];
  logic [2:0]  osel [NDUT];
  logic [9:0]  vr [NDUT];
  logic [9:0]  vg [NDUT];
  logic [9:0]  vb [NDUT];
  logic        hs [NDUT];
  logic        vs [NDUT];
  logic        bn [NDUT];
  logic        sn [NDUT];
  logic        fs [NDUT];

  geom_t geo [NDUT] = '{
    '{720, 16, 62, 60, 480, 9, 6, 30},
    '{720, 16, 62, 60, 480, 9, 6, 30},
    '{20, 2, 3, 3, 12, 2, 2, 3}
  };
  int lat [NDUT] = '{1, 2, 2};

  int          n;
  bit          romConst;
  logic [9:0]  saltG;
  logic [9:0]  saltB;
  logic [18:0] hist [NDUT][2];
  logic [2:0]  selExp [NDUT];
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  vga_addr_ctrl #(.RD_LAT(1)) dut0 (
    .VGA_CTRL_CLK(clk), .DLY_RST_2(rst), .iSEL(isel),
    .iRed(red[0]), .iGreen(green[0]), .iBlue(blue[0]),
    .oADDR(addr[0]), .oSEL(osel[0]),
    .oVGA_R(vr[0]), .oVGA_G(vg[0]), .oVGA_B(vb[0]),
    .oVGA_HS(hs[0]), .oVGA_VS(vs[0]), .oVGA_BLANK_N(bn[0]),
    .oVGA_SYNC_N(sn[0]), .oFRAME_START(fs[0]));

  vga_addr_ctrl #(.RD_LAT(2)) dut1 (
    .VGA_CTRL_CLK(clk), .DLY_RST_2(rst), .iSEL(isel),
    .iRed(red[1]), .iGreen(green[1]), .iBlue(blue[1]),
    .oADDR(addr[1]), .oSEL(osel[1]),
    .oVGA_R(vr[1]), .oVGA_G(vg[1]), .oVGA_B(vb[1]),
    .oVGA_HS(hs[1]), .oVGA_VS(vs[1]), .oVGA_BLANK_N(bn[1]),
    .oVGA_SYNC_N(sn[1]), .oFRAME_START(fs[1]));

  vga_addr_ctrl #(.RD_LAT(2), .HACT(20), .HFP(2), .HSYNC(3), .HBP(3),
                  .VACT(12), .VFP(2), .VSYNC(2), .VBP(3)) dut2 (
    .VGA_CTRL_CLK(clk), .DLY_RST_2(rst), .iSEL(isel),
    .iRed(red[2]), .iGreen(green[2]), .iBlue(blue[2]),
    .oADDR(addr[2]), .oSEL(osel[2]),
    .oVGA_R(vr[2]), .oVGA_G(vg[2]), .oVGA_B(vb[2]),
    .oVGA_HS(hs[2]), .oVGA_VS(vs[2]), .oVGA_BLANK_N(bn[2]),
    .oVGA_SYNC_N(sn[2]), .oFRAME_START(fs[2]));

  function automatic int frameLen(input int d);
    return (geo[d].hact + geo[d].hfp + geo[d].hsync + geo[d].hbp) *
           (geo[d].vact + geo[d].vfp + geo[d].vsync + geo[d].vbp);
  endfunction

  // Raster position m cycles after reset release, from plain arithmetic.
  function automatic pos_t model(input int d, input int m);
    pos_t  p;
    geom_t g;
    int    ht, f, cnt, last;
    g      = geo[d];
    ht     = g.hact + g.hfp + g.hsync + g.hbp;
    f      = m % frameLen(d);
    p.h    = f % ht;
    p.v    = f / ht;
    p.act  = (p.h < g.hact) && (p.v < g.vact);
    p.hsN  = !((p.h >= g.hact + g.hfp) && (p.h < g.hact + g.hfp + g.hsync));
    p.vsN  = !((p.v >= g.vact + g.vfp) && (p.v < g.vact + g.vfp + g.vsync));
    last   = g.hact * g.vact - 1;
    if (p.v < g.vact) cnt = p.v * g.hact + ((p.h < g.hact) ? p.h : g.hact);
    else cnt = last + 1;
    p.addr = (cnt > last) ? last : cnt;
    return p;
  endfunction

  function automatic logic [29:0] romWord(input logic [18:0] a);
    if (romConst) return {3{10'h3FF}};
    return {a[9:0], a[18:9] ^ saltG, {a[4:0], a[18:14]} ^ saltB};
  endfunction

  function automatic logic [2:0] expCtrl(input int d, input int cyc);
    pos_t p;
    if (cyc - lat[d] - 1 < 0) return 3'b011;
    p = model(d, cyc - lat[d] - 1);
    return {p.act, p.hsN, p.vsN};
  endfunction

  function automatic logic [29:0] expRgb(input int d, input int cyc);
    pos_t p;
    if (cyc - lat[d] - 1 < 0) return '0;
    p = model(d, cyc - lat[d] - 1);
    if (!p.act) return '0;
    return romWord(19'(p.addr));
  endfunction

  // Image memory: returns data for the address presented lat cycles earlier.
  initial begin
    for (int d = 0; d < NDUT; d++) begin
      hist[d][0] = '0; hist[d][1] = '0;
      red[d] = '0; green[d] = '0; blue[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        {red[d], green[d], blue[d]} = romWord(hist[d][lat[d]-1]);
        hist[d][1] = hist[d][0];
        hist[d][0] = addr[d];
      end
    end
  end

  task automatic do_reset(input int k);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (k) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    int wait_cycles;
    romConst = 1'b1;
    isel = 3'b110;
    do_reset(2);
    wait_cycles = $urandom_range(600, 800);
    repeat (wait_cycles) begin @(negedge clk); n++; end
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (osel[d] !== 3'b110) $display("[TB] FAIL sel_loaded dut%0d: got %b want 110", d, osel[d]);
      else passed++;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if ({addr[d], vr[d], hs[d], vs[d], bn[d], osel[d], fs[d], sn[d]} !==
          {19'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0})
        $display("[TB] FAIL reset_state dut%0d: addr=%0d r=%h hs=%b vs=%b bn=%b sel=%b fs=%b sn=%b",
                 d, addr[d], vr[d], hs[d], vs[d], bn[d], osel[d], fs[d], sn[d]);
      else passed++;
    end
    @(posedge clk); #1 rst = 1'b0; n = 0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if ({fs[d], addr[d], osel[d]} !== {1'b1, 19'd0, 3'b001})
        $display("[TB] FAIL release_first dut%0d: fs=%b addr=%0d sel=%b want 1/0/001", d, fs[d], addr[d], osel[d]);
      else passed++;
    end
    isel = 3'b001;
  endtask

  task automatic test_line_timing();
    int   rises[$];
    int   falls[$];
    int   highCnt, lowCnt, period, hsOfs;
    logic prevBn, prevHs;
    romConst = 1'b0;
    do_reset(2);
    prevBn = 1'b0; prevHs = 1'b1; highCnt = 0; lowCnt = 0;
    for (int i = 0; i < 3 * 858; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({bn[d], hs[d], vs[d]} !== expCtrl(d, n))
          $display("[TB] FAIL ctrl dut%0d n=%0d: got %b want %b", d, n, {bn[d], hs[d], vs[d]}, expCtrl(d, n));
        else passed++;
      end
      if (bn[0] && !prevBn) rises.push_back(n);
      if (!hs[0] && prevHs) falls.push_back(n);
      if (rises.size() == 1) begin
        if (bn[0]) highCnt++;
        if (!hs[0]) lowCnt++;
      end
      prevBn = bn[0]; prevHs = hs[0];
      n++;
    end
    period = (rises.size() >= 2) ? rises[1] - rises[0] : -1;
    hsOfs  = (rises.size() >= 1 && falls.size() >= 1) ? falls[0] - rises[0] : -1;
    checks++;
    if (period !== 858) $display("[TB] FAIL line_period: got %0d want 858", period);
    else passed++;
    checks++;
    if (hsOfs !== 736) $display("[TB] FAIL hs_offset: got %0d want 736", hsOfs);
    else passed++;
    checks++;
    if (highCnt !== 720) $display("[TB] FAIL blank_high_len: got %0d want 720", highCnt);
    else passed++;
    checks++;
    if (lowCnt !== 62) $display("[TB] FAIL hs_low_len: got %0d want 62", lowCnt);
    else passed++;
  endtask

  task automatic test_addressing();
    pos_t p;
    romConst = 1'b0;
    do_reset(3);
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        p = model(d, n);
        checks++;
        if (addr[d] !== 19'(p.addr))
          $display("[TB] FAIL addr dut%0d n=%0d: got %0d want %0d", d, n, addr[d], p.addr);
        else passed++;
        checks++;
        if (fs[d] !== ((n % frameLen(d)) == 0))
          $display("[TB] FAIL frame_start dut%0d n=%0d: got %b", d, n, fs[d]);
        else passed++;
      end
      if (n == 719 || n == 800 || n == 858) begin
        checks++;
        if (addr[0] !== ((n == 719) ? 19'd719 : 19'd720))
          $display("[TB] FAIL addr_line_edge n=%0d: got %0d", n, addr[0]);
        else passed++;
      end
      if (n == 327 || n == 400 || n == 532) begin
        checks++;
        if (addr[2] !== ((n == 532) ? 19'd0 : 19'd239))
          $display("[TB] FAIL addr_frame_edge n=%0d: got %0d", n, addr[2]);
        else passed++;
      end
      n++;
    end
  endtask

  task automatic test_blanking();
    logic [2:0] e;
    romConst = 1'b1;
    do_reset(2);
    for (int i = 0; i < 2 * 858; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        e = expCtrl(d, n);
        checks++;
        if ({vr[d], vg[d], vb[d]} !== (e[2] ? {30{1'b1}} : 30'd0))
          $display("[TB] FAIL blank_rgb dut%0d n=%0d: got %h/%h/%h blank=%b", d, n, vr[d], vg[d], vb[d], e[2]);
        else passed++;
      end
      n++;
    end
  endtask

  task automatic test_select();
    romConst = 1'b0;
    isel = 3'b001;
    do_reset(2);
    for (int d = 0; d < NDUT; d++) selExp[d] = 3'b001;
    for (int i = 0; i < 3 * 532 + 10; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        checks++;
        if (osel[d] !== selExp[d])
          $display("[TB] FAIL sel dut%0d n=%0d: got %b want %b", d, n, osel[d], selExp[d]);
        else passed++;
      end
      if (n == 531 || n == 532 || n == 533) begin
        checks++;
        if (osel[2] !== ((n == 533) ? 3'b100 : 3'b001))
          $display("[TB] FAIL sel_frame_edge n=%0d: got %b", n, osel[2]);
        else passed++;
      end
      if (n == 6 * 28) isel = 3'b100;
      else if (n > 533) isel = 3'($urandom);
      for (int d = 0; d < NDUT; d++)
        if ((n % frameLen(d)) == 0) selExp[d] = isel;
      n++;
    end
  endtask

  task automatic test_alignment();
    romConst = 1'b0;
    saltG = 10'($urandom);
    saltB = 10'($urandom);
    do_reset(2);
    for (int i = 0; i < 2 * 858 + 8; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({vr[d], vg[d], vb[d]} !== expRgb(d, n))
          $display("[TB] FAIL rgb dut%0d n=%0d: got %h want %h", d, n, {vr[d], vg[d], vb[d]}, expRgb(d, n));
        else passed++;
        if (n == 858 + lat[d] + 1) begin
          checks++;
          if (vr[d] !== 10'h2D0)
            $display("[TB] FAIL line1_first_red dut%0d: got %h want 2d0", d, vr[d]);
          else passed++;
        end
      end
      n++;
    end
  endtask

  task automatic test_mid_frame_reset();
    pos_t p;
    int   runLen;
    romConst = 1'b0;
    isel = 3'($urandom);
    do_reset(2);
    runLen = $urandom_range(50, 500);
    repeat (runLen) begin @(negedge clk); n++; end
    do_reset($urandom_range(1, 3));
    for (int d = 0; d < NDUT; d++) selExp[d] = 3'b001;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        p = model(d, n);
        checks++;
        if ({addr[d], fs[d], osel[d]} !== {19'(p.addr), (n % frameLen(d)) == 0, selExp[d]})
          $display("[TB] FAIL restart_state dut%0d n=%0d: addr=%0d fs=%b sel=%b want addr=%0d sel=%b",
                   d, n, addr[d], fs[d], osel[d], p.addr, selExp[d]);
        else passed++;
        checks++;
        if ({bn[d], hs[d], vs[d], vr[d], vg[d], vb[d]} !== {expCtrl(d, n), expRgb(d, n)})
          $display("[TB] FAIL restart_out dut%0d n=%0d: got %b/%h want %b/%h",
                   d, n, {bn[d], hs[d], vs[d]}, {vr[d], vg[d], vb[d]}, expCtrl(d, n), expRgb(d, n));
        else passed++;
      end
      isel = 3'($urandom);
      for (int d = 0; d < NDUT; d++)
        if ((n % frameLen(d)) == 0) selExp[d] = isel;
      n++;
    end
  endtask

  initial begin
    saltG = 10'($urandom);
    saltB = 10'($urandom);
    romConst = 1'b0;
    n = 0;
    $display("[TB] vga_addr_ctrl bench starting");
    test_reset();
    test_line_timing();
    test_addressing();
    test_blanking();
    test_select();
    test_alignment();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_addr_ctrl.md
VGA_ADDR_CTRL -- requirements
Module: vga_addr_ctrl

Interface
REQ-001 H_ACT, 720, active pixels per line.
REQ-002 H_FP/H_SYNC/H_BP, 16/62/60, horizontal porch and sync widths; line total 858.
REQ-003 V_ACT, 480, active lines per frame.
REQ-004 V_FP/V_SYNC/V_BP, 9/6/30, vertical porch and sync widths; frame total 525.
REQ-005 RD_LAT, 1, cycles from oADDR to valid iRed/iGreen/iBlue (image ROM read latency).
REQ-006 VGA_CTRL_CLK  in  1  pixel clock, sole clock.
REQ-007 DLY_RST_2  in  1  reset, synchronous, active-high.
REQ-008 iSEL  in  3  raw image select.
REQ-009 iRed/iGreen/iBlue  in  10 each  pixel colour returned for oADDR.
REQ-010 oADDR  out  19  linear pixel address to image source.
REQ-011 oSEL  out  3  frame-stable image select to image source.
REQ-012 oVGA_R/oVGA_G/oVGA_B  out  10 each  registered colour to DAC.
REQ-013 oVGA_HS/oVGA_VS  out  1 each  syncs, active-low.
REQ-014 oVGA_BLANK_N  out  1  high during active video; oVGA_SYNC_N  out  1  constant 0.
REQ-015 oFRAME_START  out  1  one-cycle pulse at frame origin.

Function
REQ-016 h_cnt SHALL count 0..857, wrapping to 0; v_cnt SHALL advance on h_cnt wrap, counting 0..524, wrapping to 0.
REQ-017 Active region SHALL be h_cnt<720 and v_cnt<480; raw HS low for h_cnt in 736..797; raw VS low for v_cnt in 489..494.
REQ-018 oADDR SHALL be a registered incrementing counter (no multiplier): +1 after each active cycle, held during blanking, cleared to 0 when h_cnt=857 and v_cnt=524.
REQ-019 oADDR SHALL equal v_cnt*720+h_cnt for every active cycle; range 0..345599, never exceeding 345599.
REQ-020 oFRAME_START SHALL be 1 exactly in the cycle h_cnt=0, v_cnt=0.
REQ-021 oSEL SHALL load iSEL only in the oFRAME_START cycle, appearing the next cycle; iSEL changes mid-frame SHALL have no effect until next frame origin.
REQ-022 Active, HS and VS SHALL be delayed RD_LAT+1 cycles so outputs align with returned pixel data.
REQ-023 oVGA_R/G/B SHALL register iRed/iGreen/iBlue when delayed active=1, else 0.
REQ-024 oVGA_BLANK_N SHALL equal delayed active; oVGA_HS/oVGA_VS delayed raw syncs; all registered.
REQ-025 Total latency counter-state to DAC pins SHALL be RD_LAT+1 cycles for every output.

Reset
REQ-026 While DLY_RST_2=1 at a clock edge: h_cnt, v_cnt, oADDR=0; oSEL=3'b001; oVGA_R/G/B=0; oVGA_HS=oVGA_VS=1; oVGA_BLANK_N=0; oFRAME_START=0; delay lines cleared to inactive (active 0, syncs 1).
REQ-027 Reset asserted mid-frame SHALL abort the frame; first cycle after release SHALL be h_cnt=0, v_cnt=0 with oFRAME_START=1.

Structure
REQ-028 Package vga_timing_pkg SHALL hold H/V timing constants, totals and address width (19).
REQ-029 Single sub-module vga_delay_line (parameterised depth/width shift register, synchronous reset value) SHALL align active/HS/VS.

Verification
REQ-030 Reset: assert DLY_RST_2 mid-line, iRed=3FF -> next edge oADDR=0, oVGA_R=0, HS=VS=1, BLANK_N=0, oSEL=001; after release oFRAME_START=1 first cycle.
REQ-031 Line timing: RD_LAT=1 -> oVGA_BLANK_N high 720 cycles per line, HS low 62 cycles starting 736 cycles after first BLANK_N rise, line period 858.
REQ-032 Addressing: oADDR=719 at last pixel of line 0, 720 at first pixel of line 1, 345599 at last active pixel, 0 at next frame first pixel; held during blanking.
REQ-033 Blanking: iRed/iGreen/iBlue=3FF constant -> oVGA_R/G/B=3FF only while BLANK_N=1, 0 otherwise.
REQ-034 Select: iSEL 001->100 at line 200 -> oSEL stays 001 to frame end, becomes 100 cycle after next oFRAME_START.
REQ-035 Alignment: ROM model returning iRed=oADDR[9:0] with RD_LAT=1 and 2 -> oVGA_R on first active output of line 1 equals 720[9:0]=0x2D0.
